// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encodings, frame constants and baud helpers.
// The PARITY state exists only when UART_TX_PARITY_EN is defined.
package uart_transmitter_pkg;

  localparam int DATA_BITS = 8;
  localparam int STOP_BITS = 1;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;
`else
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    STOP   = 3'd4
  } tx_state_t;
`endif

  function automatic int bit_period(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // A one-cycle bit period still needs a 1-bit counter to stay legal.
  function automatic int counter_width(input int period);
    return (period > 1) ? $clog2(period) : 1;
  endfunction

endpackage

// File: rtl/uart_transmitter_if.sv
// Character handshake between a byte source (master) and the UART transmitter (slave).
interface uart_transmitter_if;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;

  modport master (output data_in, output data_in_valid, input data_in_ready);
  modport slave  (input data_in, input data_in_valid, output data_in_ready);
endinterface

// File: rtl/uart_transmitter_baud_tick.sv
// Bit-period counter shared by the UART transmitter and receiver: counts 0..T-1
// while enabled, pulses tick on T-1, and holds 0 while disabled.
module uart_baud_tick
  import uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);
  localparam int            T    = bit_period(CLOCK_FREQ, BAUD_RATE);
  localparam int            CW   = counter_width(T);
  localparam logic [CW-1:0] LAST = CW'(T - 1);

  logic [CW-1:0] count;
  logic [CW-1:0] count_next;

  assign tick       = en && (count == LAST);
  assign count_next = (!en || tick) ? '0 : count + CW'(1);

  REGISTER_R_CE #(.N(CW), .INIT('0)) count_reg (
    .q(count), .d(count_next), .ce(1'b1), .rst(rst), .clk(clk)
  );
endmodule

// File: rtl/uart_transmitter_regs.sv
// Register primitives: REGISTER_R_CE (sync reset to INIT, clock enable) and
// REGISTER_CE (clock enable only).
module REGISTER_R_CE #(
  parameter int           N    = 1,
  parameter logic [N-1:0] INIT = '0
) (
  output logic [N-1:0] q,
  input  logic [N-1:0] d,
  input  logic         ce,
  input  logic         rst,
  input  logic         clk
);
  always_ff @(posedge clk) begin
    if (rst)
      q <= INIT;
    else if (ce)
      q <= d;
  end
endmodule

module REGISTER_CE #(
  parameter int N = 1
) (
  output logic [N-1:0] q,
  input  logic [N-1:0] d,
  input  logic         ce,
  input  logic         clk
);
  always_ff @(posedge clk) begin
    if (ce)
      q <= d;
  end
endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a registered serial line; defining UART_TX_PARITY_EN
// inserts an even-parity bit between the data bits and the stop bit.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQ = 125_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic                clk,
  input  logic                rst,
  uart_transmitter_if.slave   in_if,
  output logic                serial_out
);
  logic [2:0] state_q;
  tx_state_t  state;
  tx_state_t  state_next;
  logic       tick;
  logic       fire;
  logic       last_bit;
  logic [2:0] bit_cnt;
  logic [2:0] bit_cnt_next;
  logic [7:0] shift_q;
  logic [7:0] shift_next;
  logic [7:0] shift_after;
  logic       shift_ce;
  logic       serial_next;

  assign state               = tx_state_t'(state_q);
  assign in_if.data_in_ready = (state == IDLE);
  assign fire                = in_if.data_in_valid && in_if.data_in_ready;
  assign last_bit            = (bit_cnt == 3'(DATA_BITS - 1));

  uart_baud_tick #(.CLOCK_FREQ(CLOCK_FREQ), .BAUD_RATE(BAUD_RATE)) baud (
    .clk(clk), .rst(rst), .en(state != IDLE), .tick(tick)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (fire) state_next = START;
      START:  if (tick) state_next = DATA;
`ifdef UART_TX_PARITY_EN
      DATA:   if (tick && last_bit) state_next = PARITY;
      PARITY: if (tick) state_next = STOP;
`else
      DATA:   if (tick && last_bit) state_next = STOP;
`endif
      STOP:   if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The shift register is loaded once on fire, so later data_in changes cannot leak in.
  assign shift_ce    = fire || ((state == DATA) && tick);
  assign shift_next  = fire ? in_if.data_in : {1'b0, shift_q[7:1]};
  assign shift_after = shift_ce ? shift_next : shift_q;

  always_comb begin
    bit_cnt_next = 3'd0;
    if (state == DATA) begin
      if (tick)
        bit_cnt_next = last_bit ? 3'd0 : bit_cnt + 3'd1;
      else
        bit_cnt_next = bit_cnt;
    end
  end

`ifdef UART_TX_PARITY_EN
  logic parity_q;

  REGISTER_CE #(.N(1)) parity_reg (
    .q(parity_q), .d(^in_if.data_in), .ce(fire), .clk(clk)
  );
`endif

  // The line is decoded from the state being entered so it changes on the same edge.
  always_comb begin
    serial_next = 1'b1;
    case (state_next)
      START:   serial_next = 1'b0;
      DATA:    serial_next = shift_after[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  serial_next = parity_q;
`endif
      default: serial_next = 1'b1;
    endcase
  end

  REGISTER_R_CE #(.N(3), .INIT(IDLE)) state_reg (
    .q(state_q), .d(state_next), .ce(1'b1), .rst(rst), .clk(clk)
  );

  REGISTER_R_CE #(.N(3), .INIT(3'd0)) bit_cnt_reg (
    .q(bit_cnt), .d(bit_cnt_next), .ce(1'b1), .rst(rst), .clk(clk)
  );

  REGISTER_CE #(.N(8)) shift_reg (
    .q(shift_q), .d(shift_next), .ce(shift_ce), .clk(clk)
  );

  REGISTER_R_CE #(.N(1), .INIT(1'b1)) serial_reg (
    .q(serial_out), .d(serial_next), .ce(1'b1), .rst(rst), .clk(clk)
  );
endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter with T = 10 clocks per bit; frames are
// captured one cycle at a time and compared against hand-derived bit patterns.
module tb_uart_transmitter;

  localparam int T = 10;
`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif
  localparam int F = FB * T;

  logic clk;
  logic rst;
  logic serial_out;
  int   compared;
  int   mismatched;

  uart_transmitter_if tx_if ();

  uart_transmitter #(.CLOCK_FREQ(1000), .BAUD_RATE(100)) dut (
    .clk(clk),
    .rst(rst),
    .in_if(tx_if.slave),
    .serial_out(serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame bit b of the expected line: start, data LSB first, optional parity, stop.
  function automatic logic [FB-1:0] exp_frame(input logic [7:0] d);
    logic [FB-1:0] f;
    f       = '1;
    f[0]    = 1'b0;
    f[8:1]  = d;
`ifdef UART_TX_PARITY_EN
    f[9]    = ^d;
`endif
    return f;
  endfunction

  // Called at the negedge of cycle k+1; returns at the negedge of cycle k+F+1.
  task automatic watch_frame(output logic [FB-1:0] bits, output int glitches, output int ready_hi);
    logic line [F];
    glitches = 0;
    ready_hi = 0;
    for (int i = 0; i < F; i++) begin
      line[i] = serial_out;
      if (tx_if.data_in_ready === 1'b1) ready_hi++;
      @(negedge clk);
    end
    for (int b = 0; b < FB; b++) bits[b] = line[b*T + T/2];
    for (int i = 0; i < F; i++)
      if (line[i] !== line[(i/T)*T + T/2]) glitches++;
  endtask

  task automatic fire_byte(input logic [7:0] d);
    @(negedge clk);
    tx_if.data_in       = d;
    tx_if.data_in_valid = 1'b1;
    @(negedge clk);
    tx_if.data_in_valid = 1'b0;
  endtask

  task automatic count_low(input int cycles, output int lows);
    lows = 0;
    for (int i = 0; i < cycles; i++) begin
      if (serial_out !== 1'b1) lows++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst                 = 1'b1;
    tx_if.data_in       = 8'h00;
    tx_if.data_in_valid = 1'b0;
    repeat (2) @(negedge clk);
    compared++;
    if (serial_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_serial: got %b expected 1", serial_out);
    end
    rst = 1'b0;
    @(negedge clk);
    compared++;
    if (tx_if.data_in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_ready: got %b expected 1", tx_if.data_in_ready);
    end
  endtask

  task automatic test_send_55;
    logic [FB-1:0] bits;
    logic [FB-1:0] hand;
    int glitches, ready_hi;
`ifdef UART_TX_PARITY_EN
    hand = 11'b10010101010;
`else
    hand = 10'b1010101010;
`endif
    fire_byte(8'h55);
    watch_frame(bits, glitches, ready_hi);
    compared++;
    if (bits !== hand) begin
      mismatched++;
      $display("[TB] FAIL send55_bits: got %b expected %b", bits, hand);
    end
    compared++;
    if (glitches !== 0) begin
      mismatched++;
      $display("[TB] FAIL send55_timing: got %0d off-window cycles expected 0", glitches);
    end
    compared++;
    if (ready_hi !== 0) begin
      mismatched++;
      $display("[TB] FAIL send55_ready_low: got %0d ready cycles expected 0", ready_hi);
    end
    compared++;
    if (tx_if.data_in_ready !== 1'b1 || serial_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL send55_end: got ready=%b line=%b expected ready=1 line=1",
               tx_if.data_in_ready, serial_out);
    end
  endtask

  task automatic test_back_to_back;
    logic [FB-1:0] b1, b2;
    int g1, g2, r1, r2;
    @(negedge clk);
    tx_if.data_in       = 8'hA5;
    tx_if.data_in_valid = 1'b1;
    @(negedge clk);
    tx_if.data_in       = 8'h3C;
    watch_frame(b1, g1, r1);
    compared++;
    if (tx_if.data_in_ready !== 1'b1 || serial_out !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL b2b_gap: got ready=%b line=%b expected ready=1 line=1",
               tx_if.data_in_ready, serial_out);
    end
    @(negedge clk);
    tx_if.data_in_valid = 1'b0;
    watch_frame(b2, g2, r2);
    compared++;
    if (b1 !== exp_frame(8'hA5)) begin
      mismatched++;
      $display("[TB] FAIL b2b_first: got %b expected %b", b1, exp_frame(8'hA5));
    end
    compared++;
    if (b2 !== exp_frame(8'h3C)) begin
      mismatched++;
      $display("[TB] FAIL b2b_second: got %b expected %b", b2, exp_frame(8'h3C));
    end
    compared++;
    if (g1 + g2 + r1 + r2 !== 0) begin
      mismatched++;
      $display("[TB] FAIL b2b_timing: got %0d bad cycles expected 0", g1 + g2 + r1 + r2);
    end
  endtask

  task automatic test_data_stable;
    logic [FB-1:0] bits;
    int glitches, ready_hi;
    @(negedge clk);
    tx_if.data_in       = 8'h00;
    tx_if.data_in_valid = 1'b1;
    @(negedge clk);
    tx_if.data_in_valid = 1'b0;
    tx_if.data_in       = 8'hFF;
    watch_frame(bits, glitches, ready_hi);
    compared++;
    if (bits !== exp_frame(8'h00) || glitches !== 0) begin
      mismatched++;
      $display("[TB] FAIL data_stable: got %b (%0d glitches) expected %b",
               bits, glitches, exp_frame(8'h00));
    end
  endtask

  task automatic test_reset_mid_frame;
    logic [FB-1:0] bits;
    int glitches, ready_hi, lows;
    fire_byte(8'h0F);
    repeat (44) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    compared++;
    if (serial_out !== 1'b1 || tx_if.data_in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL midrst_recover: got line=%b ready=%b expected line=1 ready=1",
               serial_out, tx_if.data_in_ready);
    end
    count_low(6 * T, lows);
    compared++;
    if (lows !== 0) begin
      mismatched++;
      $display("[TB] FAIL midrst_no_resume: got %0d low cycles expected 0", lows);
    end
    fire_byte(8'h0F);
    watch_frame(bits, glitches, ready_hi);
    compared++;
    if (bits !== exp_frame(8'h0F) || glitches !== 0 || ready_hi !== 0) begin
      mismatched++;
      $display("[TB] FAIL midrst_clean_frame: got %b (%0d glitches, %0d ready) expected %b",
               bits, glitches, ready_hi, exp_frame(8'h0F));
    end
  endtask

  task automatic test_reset_priority;
    int lows;
    @(negedge clk);
    tx_if.data_in       = 8'h00;
    tx_if.data_in_valid = 1'b1;
    rst                 = 1'b1;
    @(negedge clk);
    tx_if.data_in_valid = 1'b0;
    rst                 = 1'b0;
    count_low(3 * T, lows);
    compared++;
    if (lows !== 0 || tx_if.data_in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL rst_priority: got %0d low cycles ready=%b expected 0 and 1",
               lows, tx_if.data_in_ready);
    end
  endtask

`ifdef UART_TX_PARITY_EN
  task automatic test_parity;
    logic [FB-1:0] bits;
    int glitches, ready_hi;
    fire_byte(8'h07);
    watch_frame(bits, glitches, ready_hi);
    compared++;
    if (bits !== 11'b11000001110 || glitches !== 0) begin
      mismatched++;
      $display("[TB] FAIL parity_frame: got %b (%0d glitches) expected 11000001110",
               bits, glitches);
    end
    compared++;
    if (ready_hi !== 0 || tx_if.data_in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL parity_ready: got %0d early ready cycles, final ready=%b expected 0 and 1",
               ready_hi, tx_if.data_in_ready);
    end
  endtask
`endif

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_send_55();
    test_back_to_back();
    test_data_stable();
    test_reset_mid_frame();
    test_reset_priority();
`ifdef UART_TX_PARITY_EN
    test_parity();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_transmitter.md
UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 SHALL have parameter CLOCK_FREQ, default 125_000_000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115_200, serial bit rate in bits/s.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port data_in  input  8  character to transmit.
REQ-006 SHALL have port data_in_valid  input  1  source offers data_in.
REQ-007 SHALL have port data_in_ready  output  1  transmitter can accept a character.
REQ-008 SHALL have port serial_out  output  1  UART line, idle high.

Function
REQ-009 SHALL define T = CLOCK_FREQ / BAUD_RATE (integer division); the baud counter width SHALL be $clog2(T).
REQ-010 SHALL implement FSM states IDLE, START, DATA, STOP (plus PARITY under REQ-023).
REQ-011 SHALL assert data_in_ready only in IDLE, combinationally decoded from state.
REQ-012 Fire = data_in_valid & data_in_ready; on fire SHALL latch data_in into an internal shift register and go IDLE->START.
REQ-013 data_in changes after the fire cycle SHALL NOT affect the frame in progress.
REQ-014 serial_out SHALL be registered: fire in cycle k -> start bit (0) on cycles k+1..k+T.
REQ-015 DATA SHALL send 8 bits, LSB first, bit i on cycles k+1+(i+1)T .. k+(i+2)T, each held exactly T cycles.
REQ-016 STOP SHALL drive 1 for exactly T cycles, then return to IDLE.
REQ-017 Back-to-back: data_in_ready SHALL rise on cycle k+10T+1; a fire then SHALL put the next start bit on cycle k+10T+2, giving exactly one extra idle-high cycle between frames.
REQ-018 Baud counter SHALL reset to 0 at each bit boundary and wrap at T-1; the bit counter SHALL count 0..7 in DATA and clear on leaving DATA.
REQ-019 In IDLE, serial_out SHALL be 1 and the counters SHALL hold 0; data_in_valid without ready SHALL be ignored.

Reset
REQ-020 On rst: state=IDLE, serial_out=1, data_in_ready=1 (from the cycle after rst), counters=0.
REQ-021 rst asserted mid-frame SHALL abandon the frame; serial_out SHALL be 1 on the next cycle; no partial resumption.
REQ-022 rst SHALL take priority over a simultaneous fire; that character SHALL be dropped.

Configuration
REQ-023 With macro UART_TX_PARITY_EN defined: a PARITY state between DATA and STOP SHALL send the even-parity bit (XOR of the 8 data bits) for T cycles, so the frame is 11T cycles and ready rises on k+11T+1.
REQ-024 Without UART_TX_PARITY_EN: no PARITY state, no parity logic, and the frame is 10T cycles as in REQ-014..REQ-017.

Structure
REQ-025 The FSM state encodings and the frame length constants (data bits 8, stop bits 1) SHALL live in the shared uart package used by the receiver and transmitter.
REQ-026 The baud counter SHALL be a sub-module uart_baud_tick (parameters CLOCK_FREQ and BAUD_RATE; inputs clk, rst, en; output tick on count T-1), reusable by the receiver.
REQ-027 State, counters, shift register and serial_out SHALL be built from the codebase's REGISTER_R_CE and REGISTER_CE primitives.

Verification (CLOCK_FREQ=1000, BAUD_RATE=100, so T=10)
REQ-028 Send 0x55 -> serial_out is 0 for 10 cycles, then 1,0,1,0,1,0,1,0, each for 10 cycles, then 1 for 10 cycles; ready is low for cycles k+1..k+100.
REQ-029 Back-to-back 0xA5 then 0x3C with valid held high -> second start bit on cycle k+102; a loopback uart_receiver returns 0xA5 then 0x3C.
REQ-030 Change data_in to 0xFF during the frame of 0x00 -> all eight data bits are 0.
REQ-031 Assert rst at cycle k+45 of a 0x0F frame -> serial_out is 1 from k+46 and ready is 1; a new fire sends a clean frame.
REQ-032 valid=1 with rst=1 in the same cycle -> no start bit follows, and serial_out stays 1.
REQ-033 With UART_TX_PARITY_EN, send 0x07 -> parity bit 1 on cycles k+91..k+100, stop bit on k+101..k+110, and ready rises on k+111.
